// File: rtl/adder_pkg.sv
// Shared constants for the adder datapath: comparator width, default bus width
// and the result-select encodings.
package adder_pkg;

  localparam int   COM_W     = 6;
  localparam int   DEFAULT_N = 16;

  localparam logic SEL_ADD   = 1'b0;
  localparam logic SEL_CMP   = 1'b1;

endpackage : adder_pkg

// File: rtl/dff_arn.sv
// Parameterised-width flop with asynchronous active-low reset to zero.
// Loads every clock; there is no enable.
module dff_arn #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : dff_arn

// File: rtl/mux2to1_output.sv
// Output-select stage: picks the adder result or the zero-extended comparator
// result and registers it, together with a carry flag, for observation.
module mux2to1_output
  import adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sum,
  input  logic             co,
  input  logic [COM_W-1:0] com_res,
  input  logic             sel,
  output logic [N-1:0]     sel_res,
  output logic             sel_co
);

  logic [N-1:0] w_cmp_ext;
  logic [N-1:0] w_res_next;
  logic         w_co_next;
  logic [N:0]   w_q;

  // Padding bits are only written when N > COM_W, so N == COM_W needs no special case.
  always_comb begin
    w_cmp_ext              = '0;
    w_cmp_ext[COM_W-1:0]   = com_res;
  end

  // An unknown select falls to the default arm so X reaches the outputs in simulation.
  always_comb begin
    w_res_next = 'x;
    w_co_next  = 1'bx;
    case (sel)
      SEL_ADD: begin
        w_res_next = sum;
        w_co_next  = co;
      end
      SEL_CMP: begin
        w_res_next = w_cmp_ext;
        w_co_next  = 1'b0;
      end
      default: begin
        w_res_next = 'x;
        w_co_next  = 1'bx;
      end
    endcase
  end

  dff_arn #(
    .W (N + 1)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({w_co_next, w_res_next}),
    .o_q   (w_q)
  );

  assign sel_res = w_q[N-1:0];
  assign sel_co  = w_q[N];

endmodule : mux2to1_output

// File: tb/tb_mux2to1_output.sv
// Directed bench for mux2to1_output at N=16 and N=6 with a scoreboard of
// expected register contents.
module tb_mux2to1_output;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        co;
  logic [5:0]  com_res;
  logic [15:0] sum16;
  logic [5:0]  sum6;
  logic [15:0] res16;
  logic        co16;
  logic [5:0]  res6;
  logic        co6;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] r16;
    logic        c16;
    logic [5:0]  r6;
    logic        c6;
  } exp_t;

  exp_t sb[$];

  mux2to1_output #(.N(16)) u_dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum     (sum16),
    .co      (co),
    .com_res (com_res),
    .sel     (sel),
    .sel_res (res16),
    .sel_co  (co16)
  );

  mux2to1_output #(.N(6)) u_dut6 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum     (sum6),
    .co      (co),
    .com_res (com_res),
    .sel     (sel),
    .sel_res (res6),
    .sel_co  (co6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res16"}, res16, 16'h0000);
    chk({tag, "_co16"},  {15'd0, co16}, 16'h0000);
    chk({tag, "_res6"},  {10'd0, res6}, 16'h0000);
    chk({tag, "_co6"},   {15'd0, co6},  16'h0000);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty observed=%h expected=entry", tag, res16);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res16"}, res16, e.r16);
      chk({tag, "_co16"},  {15'd0, co16}, {15'd0, e.c16});
      chk({tag, "_res6"},  {10'd0, res6}, {10'd0, e.r6});
      chk({tag, "_co6"},   {15'd0, co6},  {15'd0, e.c6});
    end
  endtask

  // Drive inputs on the falling edge, predict, then check 1 time unit after the load edge.
  task automatic step(input string tag, input logic s, input logic [15:0] d16,
                      input logic [5:0] d6, input logic c, input logic [5:0] cm);
    exp_t e;
    @(negedge clk);
    sel = s; sum16 = d16; sum6 = d6; co = c; com_res = cm;
    e.r16 = s ? {10'd0, cm} : d16;
    e.c16 = s ? 1'b0 : c;
    e.r6  = s ? cm : d6;
    e.c6  = s ? 1'b0 : c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; co = 1'b1; sum16 = 16'hFFFF; sum6 = 6'h3F; com_res = 6'h00;
    #1;
    chk_zero("reset_no_edge");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held_edges");

    @(negedge clk);
    rst_n = 1'b1;

    step("adder_zero",   1'b0, 16'h0000, 6'h00, 1'b0, 6'b111111);
    step("cmp_3f",       1'b1, 16'h0000, 6'h00, 1'b0, 6'b111111);
    step("carry_a5c3",   1'b0, 16'hA5C3, 6'h03, 1'b1, 6'b111111);
    step("cmp_15",       1'b1, 16'hA5C3, 6'h03, 1'b1, 6'b010101);
    step("n6_cmp_2a",    1'b1, 16'h0000, 6'h00, 1'b1, 6'b101010);
    step("n6_add_3f",    1'b0, 16'hFFFF, 6'h3F, 1'b1, 6'b101010);

    // Between-edge change must not show until the next edge.
    step("lat_load",     1'b0, 16'h1234, 6'h12, 1'b0, 6'h00);
    @(negedge clk);
    sum16 = 16'h5678; sum6 = 6'h38; co = 1'b1;
    #1;
    chk("lat_hold_res16", res16, 16'h1234);
    chk("lat_hold_co16",  {15'd0, co16}, 16'h0000);
    chk("lat_hold_res6",  {10'd0, res6}, 16'h0012);
    step("lat_update",   1'b0, 16'h5678, 6'h38, 1'b1, 6'h00);

    step("sim_sel_data", 1'b1, 16'h9999, 6'h19, 1'b1, 6'h2A);
    step("back_to_add",  1'b0, 16'hBEEF, 6'h2F, 1'b1, 6'h2A);

    // Mid-cycle reset discards the pending inputs.
    @(negedge clk);
    sum16 = 16'hCAFE; sum6 = 6'h3E; co = 1'b1; sel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midop_reset_now");
    @(posedge clk);
    #1;
    chk_zero("midop_reset_edge");
    step_after_release();

    step("post_cmp",     1'b1, 16'h0000, 6'h00, 1'b0, 6'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Release reset on a falling edge, then the next rising edge is the first load.
  task automatic step_after_release();
    exp_t e;
    @(negedge clk);
    sum16 = 16'h1111; sum6 = 6'h11; co = 1'b0; sel = 1'b0; com_res = 6'h00;
    rst_n = 1'b1;
    #1;
    chk_zero("release_before_edge");
    e.r16 = 16'h1111; e.c16 = 1'b0; e.r6 = 6'h11; e.c6 = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check("first_load_after_release");
  endtask

endmodule : tb_mux2to1_output
